gshare_predictor: RTL and testbench

- Branch direction and target predictor shared by the Fetch and Execute stages of the 5-stage pipeline.
- Fetch side: combinational lookup. It supplies `hit`, `prediction` and `GHR_value` to Decode, plus the predicted next PC.
- Execute side: consumes the branch record that Decode registers (`Pc_Xor_GR`, `real_Value`, `prediction_Reg`, `hit_Reg`, `pc_Reg`).
  - Trains the pattern table, BTB and global history.
  - Raises a mispredict redirect.

---
 rtl/pred_pkg.sv | 26 ++
 rtl/gshare_predictor_if.sv | 34 +++
 rtl/sat_counter2.sv | 21 ++
 rtl/gshare_predictor.sv | 92 +++++++++
 tb/tb_gshare_predictor.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pred_pkg.sv
// Shared types and sizing for the gshare branch predictor.
// Holds the 2-bit counter encodings, the PHT reset value and the default widths.
package pred_pkg;

    localparam int unsigned PC_W  = 5;
    localparam int unsigned GHR_W = 4;
    localparam int unsigned PHT_N = 2 ** GHR_W;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned BTB_N = 2 ** PC_W;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt2_t;

    localparam cnt2_t PHT_RST = WNT;

    // Direct-mapped BTB entry; indexed by the full PC, so no tag is kept.
    typedef struct packed {
        logic            v;
        logic [PC_W-1:0] tgt;
    } btb_entry_t;

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch lookup and Execute update bundle between the pipeline and the gshare predictor.
// The pipeline side is the master; the predictor is the slave.
interface gshare_predictor_if;
    import pred_pkg::*;

    logic [PC_W-1:0]  lk_pc;
    logic             hit;
    logic             prediction;
    logic [GHR_W-1:0] GHR_value;
    logic [PC_W-1:0]  pred_next_pc;

    logic             upd_valid;
    logic [GHR_W-1:0] upd_idx;
    logic [PC_W-1:0]  upd_pc;
    logic [PC_W-1:0]  upd_target;
    logic             upd_taken;
    logic             upd_pred;
    logic             upd_hit;

    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output lk_pc, upd_valid, upd_idx, upd_pc, upd_target, upd_taken, upd_pred, upd_hit,
        input  hit, prediction, GHR_value, pred_next_pc, mispredict, redirect_pc, mispredict_cnt
    );

    modport slave (
        input  lk_pc, upd_valid, upd_idx, upd_pc, upd_target, upd_taken, upd_pred, upd_hit,
        output hit, prediction, GHR_value, pred_next_pc, mispredict, redirect_pc, mispredict_cnt
    );

endinterface

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state: steps toward ST when taken, toward SNT otherwise.
module sat_counter2
    import pred_pkg::*;
(
    input  cnt2_t cnt_i,
    input  logic  taken_i,
    output cnt2_t cnt_next_c
);

    always_comb begin
        cnt_next_c = cnt_i;
        unique case (cnt_i)
            SNT: cnt_next_c = taken_i ? WNT : SNT;
            WNT: cnt_next_c = taken_i ? WT  : SNT;
            WT:  cnt_next_c = taken_i ? ST  : WNT;
            ST:  cnt_next_c = taken_i ? ST  : WT;
            default: cnt_next_c = cnt_i;
        endcase
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor with a direct-mapped BTB: combinational Fetch lookup,
// Execute-side training, mispredict detection and a saturating mispredict counter.
module gshare_predictor
    import pred_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    gshare_predictor_if.slave  bus
);

    cnt2_t            pht_q [PHT_N];
    cnt2_t            pht_d [PHT_N];
    btb_entry_t       btb_q [BTB_N];
    btb_entry_t       btb_d [BTB_N];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    logic [GHR_W-1:0] lk_idx;
    cnt2_t            lk_cnt;
    btb_entry_t       lk_ent;
    logic             lk_pred;
    btb_entry_t       upd_ent;
    logic             eff_pred;
    logic             misp;
    cnt2_t            upd_cnt_next;

    // Fetch lookup reads only registered state, so same-cycle training shows up next cycle.
    assign lk_idx  = bus.lk_pc[GHR_W-1:0] ^ ghr_q;
    assign lk_cnt  = pht_q[lk_idx];
    assign lk_ent  = btb_q[bus.lk_pc];
    assign lk_pred = (lk_cnt == WT) || (lk_cnt == ST);

    assign bus.hit            = lk_ent.v;
    assign bus.prediction     = lk_pred;
    assign bus.GHR_value      = ghr_q;
    assign bus.pred_next_pc   = (lk_ent.v && lk_pred) ? lk_ent.tgt : PC_W'(bus.lk_pc + 1'b1);
    assign bus.mispredict_cnt = mcnt_q;

    // Fetch only redirected when both the BTB hit and the PHT said taken.
    assign upd_ent  = btb_q[bus.upd_pc];
    assign eff_pred = bus.upd_pred & bus.upd_hit;
    assign misp     = bus.upd_valid &
                      ((bus.upd_taken != eff_pred) |
                       (bus.upd_taken & eff_pred & (upd_ent.tgt != bus.upd_target)));

    assign bus.mispredict  = misp;
    assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : PC_W'(bus.upd_pc + 1'b1);

    sat_counter2 u_pht_cnt (
        .cnt_i      (pht_q[bus.upd_idx]),
        .taken_i    (bus.upd_taken),
        .cnt_next_c (upd_cnt_next)
    );

    // Training: PHT, non-speculative history, BTB on taken, statistics on mispredict.
    always_comb begin
        pht_d  = pht_q;
        btb_d  = btb_q;
        ghr_d  = ghr_q;
        mcnt_d = mcnt_q;
        if (bus.upd_valid) begin
            pht_d[bus.upd_idx] = upd_cnt_next;
            ghr_d              = {ghr_q[GHR_W-2:0], bus.upd_taken};
            if (bus.upd_taken) begin
                btb_d[bus.upd_pc].v   = 1'b1;
                btb_d[bus.upd_pc].tgt = bus.upd_target;
            end
            if (misp && (mcnt_q != {CNT_W{1'b1}})) begin
                mcnt_d = mcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < PHT_N; i++) begin
                pht_q[i] <= PHT_RST;
            end
            for (int unsigned i = 0; i < BTB_N; i++) begin
                btb_q[i] <= '0;
            end
            ghr_q  <= '0;
            mcnt_q <= '0;
        end else begin
            pht_q  <= pht_d;
            btb_q  <= btb_d;
            ghr_q  <= ghr_d;
            mcnt_q <= mcnt_d;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: an array-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gshare_predictor;
    import pred_pkg::*;

    logic clk = 1'b0;
    logic reset;

    gshare_predictor_if bus ();

    gshare_predictor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state kept as plain integers.
    int m_pht [16];
    bit m_bv  [32];
    int m_bt  [32];
    int m_ghr;
    int m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_pht[i] = 1;
        for (int i = 0; i < 32; i++) begin
            m_bv[i] = 1'b0;
            m_bt[i] = 0;
        end
        m_ghr = 0;
        m_cnt = 0;
    endfunction

    function automatic int e_pred();
        int idx;
        idx = (int'(bus.lk_pc) % 16) ^ m_ghr;
        return (m_pht[idx] >= 2) ? 1 : 0;
    endfunction

    function automatic int e_next();
        int lk;
        lk = int'(bus.lk_pc);
        return (m_bv[lk] && (e_pred() == 1)) ? m_bt[lk] : (lk + 1) % 32;
    endfunction

    function automatic int e_misp();
        int eff;
        int tk;
        if (!bus.upd_valid) return 0;
        eff = (bus.upd_pred && bus.upd_hit) ? 1 : 0;
        tk  = bus.upd_taken ? 1 : 0;
        if (tk != eff) return 1;
        if ((tk == 1) && (m_bt[int'(bus.upd_pc)] != int'(bus.upd_target))) return 1;
        return 0;
    endfunction

    function automatic int e_redir();
        return bus.upd_taken ? int'(bus.upd_target) : (int'(bus.upd_pc) + 1) % 32;
    endfunction

    // Model training on the same edges as the DUT.
    always @(posedge clk or negedge reset) begin
        int idx;
        int pc;
        int tk;
        if (!reset) begin
            model_reset();
        end else if (bus.upd_valid) begin
            idx = int'(bus.upd_idx);
            pc  = int'(bus.upd_pc);
            tk  = bus.upd_taken ? 1 : 0;
            if ((e_misp() == 1) && (m_cnt < 65535)) m_cnt++;
            if (tk == 1) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
            else         m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
            m_ghr = ((m_ghr * 2) + tk) % 16;
            if (tk == 1) begin
                m_bv[pc] = 1'b1;
                m_bt[pc] = int'(bus.upd_target);
            end
        end
    end

    // Every-cycle comparison, mid-way between active edges.
    always @(negedge clk) begin
        chk("hit",            int'(bus.hit),            m_bv[int'(bus.lk_pc)] ? 1 : 0);
        chk("prediction",     int'(bus.prediction),     e_pred());
        chk("GHR_value",      int'(bus.GHR_value),      m_ghr);
        chk("pred_next_pc",   int'(bus.pred_next_pc),   e_next());
        chk("mispredict",     int'(bus.mispredict),     e_misp());
        chk("mispredict_cnt", int'(bus.mispredict_cnt), m_cnt);
        if (e_misp() == 1) chk("redirect_pc", int'(bus.redirect_pc), e_redir());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input bit v, input int idx, input int pc, input int tgt,
                       input bit tk, input bit pr, input bit ht);
        bus.upd_valid  = v;
        bus.upd_idx    = GHR_W'(idx);
        bus.upd_pc     = PC_W'(pc);
        bus.upd_target = PC_W'(tgt);
        bus.upd_taken  = tk;
        bus.upd_pred   = pr;
        bus.upd_hit    = ht;
    endtask

    initial begin
        reset     = 1'b0;
        bus.lk_pc = PC_W'(5);
        upd(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        #1;
        chk("rst hit",  int'(bus.hit), 0);
        chk("rst pred", int'(bus.prediction), 0);
        chk("rst ghr",  int'(bus.GHR_value), 0);
        chk("rst next", int'(bus.pred_next_pc), 6);
        chk("rst cnt",  int'(bus.mispredict_cnt), 0);
        reset = 1'b1;

        // First taken branch with no BTB hit.
        tick();
        upd(1, 3, 3, 12, 1, 0, 0);
        #1;
        chk("first misp",  int'(bus.mispredict), 1);
        chk("first redir", int'(bus.redirect_pc), 12);
        tick();
        upd(0, 0, 0, 0, 0, 0, 0);
        bus.lk_pc = PC_W'(2);
        #1;
        chk("first ghr",   int'(bus.GHR_value), 1);
        chk("first cnt",   int'(bus.mispredict_cnt), 1);
        chk("model pht3",  m_pht[3], 2);
        chk("lk2 pred",    int'(bus.prediction), 1);

        // Correct not-taken at pc 31: wrap on redirect, BTB untouched; four shift ghr back to 0.
        for (int i = 0; i < 4; i++) begin
            tick();
            upd(1, 0, 31, 0, 0, 0, 1);
            #1;
            chk("nt misp", int'(bus.mispredict), 0);
            if (i == 0) chk("nt redir wrap", int'(bus.redirect_pc), 0);
        end
        tick();
        upd(0, 0, 0, 0, 0, 0, 0);
        bus.lk_pc = PC_W'(3);
        #1;
        chk("trained ghr",  int'(bus.GHR_value), 0);
        chk("trained hit",  int'(bus.hit), 1);
        chk("trained pred", int'(bus.prediction), 1);
        chk("trained next", int'(bus.pred_next_pc), 12);
        bus.lk_pc = PC_W'(31);
        #1;
        chk("nt btb hit31", int'(bus.hit), 0);

        // Saturation on idx 5: 01->10->11->11->11, then 10 after one not-taken.
        for (int i = 0; i < 4; i++) begin
            tick();
            upd(1, 5, 7, 20, 1, 0, 0);
        end
        tick();
        upd(0, 0, 0, 0, 0, 0, 0);
        bus.lk_pc = PC_W'(10);
        #1;
        chk("model sat pht5", m_pht[5], 3);
        chk("sat pred",       int'(bus.prediction), 1);
        tick();
        upd(1, 5, 7, 20, 0, 0, 0);
        tick();
        upd(0, 0, 0, 0, 0, 0, 0);
        bus.lk_pc = PC_W'(11);
        #1;
        chk("model pht5 dec", m_pht[5], 2);
        chk("dec pred",       int'(bus.prediction), 1);
        chk("dec cnt",        int'(bus.mispredict_cnt), 5);
        chk("dec next",       int'(bus.pred_next_pc), 12);

        // Stale BTB target on an otherwise correct taken prediction.
        tick();
        upd(1, 6, 7, 21, 1, 1, 1);
        #1;
        chk("stale misp",  int'(bus.mispredict), 1);
        chk("stale redir", int'(bus.redirect_pc), 21);
        tick();
        upd(1, 6, 7, 21, 1, 1, 1);
        #1;
        chk("fresh misp",  int'(bus.mispredict), 0);

        // BTB collision: lookup sees the old entry until the edge.
        tick();
        upd(1, 2, 9, 4, 1, 0, 0);
        bus.lk_pc = PC_W'(9);
        #1;
        chk("coll btb old", int'(bus.hit), 0);
        tick();
        upd(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("coll btb new", int'(bus.hit), 1);

        // PHT collision on idx 12 (ghr 0111 -> lk_pc 11, then ghr 1111 -> lk_pc 3).
        tick();
        upd(1, 12, 10, 1, 1, 0, 0);
        bus.lk_pc = PC_W'(11);
        #1;
        chk("coll pht old", int'(bus.prediction), 0);
        tick();
        upd(0, 0, 0, 0, 0, 0, 0);
        bus.lk_pc = PC_W'(3);
        #1;
        chk("coll pht new", int'(bus.prediction), 1);
        chk("coll ghr",     int'(bus.GHR_value), 15);

        // Reset mid-cycle clears everything at once.
        tick();
        #1;
        reset = 1'b0;
        #1;
        chk("mid rst hit",  int'(bus.hit), 0);
        chk("mid rst pred", int'(bus.prediction), 0);
        chk("mid rst ghr",  int'(bus.GHR_value), 0);
        chk("mid rst cnt",  int'(bus.mispredict_cnt), 0);
        chk("mid rst next", int'(bus.pred_next_pc), 4);
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
